alu6_issue_queue: RTL and testbench
===================================

# alu6_issue_queue

Command front-end and result buffer for the 6-bit ALU. Accepts operand/op-code commands over a valid/ready handshake, holds them stable on the ALU inputs for one execute cycle, and captures the ALU's combinational result. Results go into a small FIFO, which downstream logic drains over a second valid/ready handshake. The ALU itself is instantiated beside this block; this block only drives its inputs and samples its output.

## Interface
Parameters:
- DEPTH, 4, result FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block accepts command this cycle
- cmd_a  input  6  operand A
- cmd_b  input  6  operand B
- cmd_op  input  2  ALU op-code
- alu_a  output  6  to ALU input A (registered)
- alu_b  output  6  to ALU input B (registered)
- alu_op  output  2  to ALU op-code (registered)
- alu_result  input  6  from ALU output, combinational
- res_valid  output  1  FIFO head holds a result
- res_ready  input  1  consumer takes head this cycle
- res_data  output  6  head result
- res_op  output  2  op-code that produced head result
- res_zero  output  1  res_data == 0
- res_neg  output  1  res_data[5]
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- busy  output  1  state == EXEC

## Operation
- ALU op-codes, all results mod 64:
  - 00 = (A<<2)+(B>>1)
  - 01 = A+3B
  - 10 = −B
  - 11 = |2A−B|, where the absolute value is taken on the 6-bit two's-complement result.
- FSM states:
  - IDLE: cmd_ready = (count < DEPTH). On cmd_valid && cmd_ready, latch cmd_a/b/op into alu_a/b/op and go to EXEC.
  - EXEC: cmd_ready = 0. At the closing edge, push {alu_op, alu_result} into the FIFO tail and go to IDLE.
- alu_a/b/op hold their last value in IDLE and change only on command acceptance.
- FIFO:
  - Circular buffer with DEPTH entries, 8 bits each (op, data), with read/write pointers wrapping modulo DEPTH.
  - Pop on res_valid && res_ready.
  - res_valid = (count != 0).
  - res_data, res_op, res_zero and res_neg are combinational from the head entry.
  - count_next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- Full: when count == DEPTH, cmd_ready is low. A command in EXEC always has a free slot, because acceptance required count < DEPTH and only that EXEC can push.
- Empty: res_valid is low, and res_* outputs are don't-care. A pop with count == 0 is ignored.
- cmd_* inputs are ignored while cmd_ready is low.

## Timing
- Reset values, applied asynchronously while rst is high:
  - state = IDLE; pointers = 0; count = 0.
  - alu_a = 0, alu_b = 0, alu_op = 0.
  - cmd_ready = 1; res_valid = 0; busy = 0.
  - res_data, res_op, res_zero and res_neg reflect entry 0, whose reset contents are 0 (so res_zero = 1).
- Latency: command accepted at edge N; ALU inputs are valid after N; result is written at edge N+1; res_valid is high after N+1 if the FIFO was empty.
- Throughput: one command per 2 cycles. cmd_ready is low during EXEC.
- Reset asserted during EXEC: the in-flight command is discarded and no push occurs. Buffered results are lost.
- Consumer back-pressure: a result in the FIFO is held indefinitely until popped.
- Pop is allowed in every state, including EXEC, and may coincide with the EXEC push.

## Test plan
- Reset then idle:
  - Required: cmd_ready = 1, res_valid = 0, count = 0, busy = 0.
  - After a command issued mid-EXEC and rst pulsed, the same values hold and no result appears.
- Op sweep, with res_ready = 1:
  - (op 01, A=5, B=7) -> res_data = 26
  - (op 00, A=3, B=10) -> 17
  - (op 10, B=1) -> 63, res_neg = 1
  - (op 11, A=10, B=30) -> 10
  - Each result appears 1 edge after acceptance, and res_op matches the issuing op.
- Wrap and zero:
  - (op 01, A=1, B=21) -> 0, res_zero = 1
  - (op 00, A=16, B=0) -> 0, res_zero = 1
- Fill, with res_ready = 0 and back-to-back commands:
  - The first 4 are accepted; count reaches 4 and cmd_ready stays low.
  - Raise res_ready for 1 cycle: one pop, count = 3, and cmd_ready high in the next IDLE.
  - Results drain in issue order.
- Simultaneous push/pop:
  - Set count = 1 and assert res_ready during an EXEC closing edge. count stays 1, and the head becomes the new result.
- Pointer wrap:
  - Issue 10 commands with random res_ready.
  - All 10 results are delivered in order with correct values against a reference model, and count never exceeds 4.

Source files
------------

// File: rtl/alu6_issue_queue_if.sv
// Command, ALU-side and result signals of alu6_issue_queue, bundled as one interface.
// master = upstream/ALU/consumer side, slave = the issue queue itself.
interface alu6_issue_queue_if #(parameter int DEPTH = 4);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [5:0]             cmd_a;
  logic [5:0]             cmd_b;
  logic [1:0]             cmd_op;
  logic [5:0]             alu_a;
  logic [5:0]             alu_b;
  logic [1:0]             alu_op;
  logic [5:0]             alu_result;
  logic                   res_valid;
  logic                   res_ready;
  logic [5:0]             res_data;
  logic [1:0]             res_op;
  logic                   res_zero;
  logic                   res_neg;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op,
           res_zero, res_neg, count, busy
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op,
           res_zero, res_neg, count, busy
  );
endinterface

// File: rtl/alu6_issue_queue.sv
// Front-end for the 6-bit ALU: latches one command per 2 cycles onto the ALU
// inputs, captures the combinational result and buffers it in a small FIFO.
module alu6_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu6_issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef struct packed {
    logic [1:0] op;
    logic [5:0] data;
  } entry_t;

  state_t        state;
  logic [5:0]    a_q, b_q;
  logic [1:0]    op_q;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  entry_t        head;
  logic          cmd_ready, res_valid, accept, push, pop;

  assign cmd_ready = (state == IDLE) && (count < FULL);
  assign res_valid = (count != '0);
  assign accept    = bus.cmd_valid && cmd_ready;
  // The EXEC cycle always pushes: acceptance already reserved a free slot.
  assign push      = (state == EXEC);
  assign pop       = res_valid && bus.res_ready;
  assign head      = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= bus.cmd_a;
          b_q   <= bus.cmd_b;
          op_q  <= bus.cmd_op;
          state <= EXEC;
        end
        EXEC: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {op_q, bus.alu_result};
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = head.data;
  assign bus.res_op    = head.op;
  assign bus.res_zero  = (head.data == 6'd0);
  assign bus.res_neg   = head.data[5];
  assign bus.count     = count;
  assign bus.busy      = (state == EXEC);
endmodule

// File: tb/tb_alu6_issue_queue.sv
// Randomized and directed bench for alu6_issue_queue against a queue-based
// model of the command/result flow, with a behavioural ALU attached.
module tb_alu6_issue_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu6_issue_queue_if #(.DEPTH(DEPTH)) bus ();
  alu6_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [5:0] alu_f(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
    logic [5:0] t;
    case (op)
      2'd0:    alu_f = 6'((a << 2) + (b >> 1));
      2'd1:    alu_f = 6'(a + 3 * b);
      2'd2:    alu_f = 6'(0 - b);
      default: begin
        t     = 6'(2 * a - b);
        alu_f = t[5] ? 6'(0 - t) : t;
      end
    endcase
  endfunction

  always_comb bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus one in-flight result.
  logic [7:0] mq[$];
  bit         m_exec = 1'b0;
  logic [7:0] m_inflight;
  logic [5:0] m_a = '0, m_b = '0;
  logic [1:0] m_op = '0;
  int         n_pop = 0, n_acc = 0;

  always @(negedge clk) begin
    bit m_ready, m_accept, m_pop;
    if (rst) begin
      mq.delete();
      m_exec = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_alu_in", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
      chk("rst_res_zero", bus.res_zero, 1);
    end else begin
      m_ready  = !m_exec && (mq.size() < DEPTH);
      m_accept = bus.cmd_valid && m_ready;
      m_pop    = bus.res_ready && (mq.size() != 0);
      chk("count", bus.count, mq.size());
      chk("count_max", bus.count <= DEPTH, 1);
      chk("res_valid", bus.res_valid, mq.size() != 0);
      chk("cmd_ready", bus.cmd_ready, m_ready);
      chk("busy", bus.busy, m_exec);
      chk("alu_in", {bus.alu_op, bus.alu_a, bus.alu_b}, {m_op, m_a, m_b});
      if (mq.size() != 0) begin
        chk("head_data", bus.res_data, mq[0][5:0]);
        chk("head_op", bus.res_op, mq[0][7:6]);
        chk("head_zero", bus.res_zero, mq[0][5:0] == 6'd0);
        chk("head_neg", bus.res_neg, mq[0][5]);
      end
      if (m_pop) begin
        void'(mq.pop_front());
        n_pop++;
      end
      if (m_exec) begin
        mq.push_back(m_inflight);
        m_exec = 1'b0;
      end
      if (m_accept) begin
        m_a = bus.cmd_a; m_b = bus.cmd_b; m_op = bus.cmd_op;
        m_inflight = {bus.cmd_op, alu_f(bus.cmd_op, bus.cmd_a, bus.cmd_b)};
        m_exec = 1'b1;
        n_acc++;
      end
    end
  end

  bit rand_rr = 1'b0;
  always @(posedge clk) if (rand_rr) begin
    #1;
    bus.res_ready = 1'($urandom_range(0, 1));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accepting edge (block in EXEC).
  task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.cmd_ready && t < 50);
    chk("send_accept", bus.cmd_ready, 1);
    step(1);
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 6'($urandom); bus.cmd_b = 6'($urandom); bus.cmd_op = 2'($urandom);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] a, b, exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int p0, a0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0;
    vecs[0] = '{2'd1, 6'd5,  6'd7,  6'd26};
    vecs[1] = '{2'd0, 6'd3,  6'd10, 6'd17};
    vecs[2] = '{2'd2, 6'd0,  6'd1,  6'd63};
    vecs[3] = '{2'd3, 6'd10, 6'd30, 6'd10};
    vecs[4] = '{2'd1, 6'd1,  6'd21, 6'd0};
    vecs[5] = '{2'd0, 6'd16, 6'd0,  6'd0};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.res_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset while a command is executing: nothing may emerge.
    send(2'd1, 6'd5, 6'd7);
    chk("mid_exec_busy", bus.busy, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_valid", bus.res_valid, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);
    chk("post_rst_busy", bus.busy, 0);

    // Op sweep plus wrap-to-zero, consumer always ready.
    bus.res_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      chk("sweep_not_yet", bus.res_valid, 0);
      step(1);
      chk("sweep_valid", bus.res_valid, 1);
      chk("sweep_data", bus.res_data, vecs[i].exp);
      chk("sweep_op", bus.res_op, vecs[i].op);
      chk("sweep_zero", bus.res_zero, vecs[i].exp == 6'd0);
      chk("sweep_neg", bus.res_neg, vecs[i].exp[5]);
    end
    step(2);

    // Fill with the consumer stalled, then free exactly one slot.
    bus.res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(2'($urandom), 6'($urandom), 6'($urandom));
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd3; bus.cmd_a = 6'd7; bus.cmd_b = 6'd2;
    step(3);
    chk("full_count", bus.count, DEPTH);
    chk("full_ready", bus.cmd_ready, 0);
    bus.res_ready = 1'b1;
    step(1);
    bus.res_ready = 1'b0;
    chk("one_pop_count", bus.count, DEPTH - 1);
    chk("one_pop_ready", bus.cmd_ready, 1);
    step(1);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    step(10);
    chk("drained", bus.count, 0);

    // Push and pop on the same edge.
    bus.res_ready = 1'b0;
    send(2'd1, 6'd5, 6'd7);
    step(1);
    chk("pp_count_pre", bus.count, 1);
    send(2'd3, 6'd10, 6'd30);
    bus.res_ready = 1'b1;
    step(1);
    bus.res_ready = 1'b0;
    chk("pp_count", bus.count, 1);
    chk("pp_head", bus.res_data, 6'd10);
    chk("pp_op", bus.res_op, 2'd3);
    bus.res_ready = 1'b1;
    step(2);

    // Pointer wrap with a randomly stalling consumer.
    p0 = n_pop; a0 = n_acc;
    rand_rr = 1'b1;
    for (int i = 0; i < 10; i++) send(2'($urandom), 6'($urandom), 6'($urandom));
    rand_rr = 1'b0;
    step(1);
    bus.res_ready = 1'b1;
    step(12);
    chk("wrap_accepted", n_acc - a0, 10);
    chk("wrap_delivered", n_pop - p0, 10);
    chk("wrap_empty", bus.res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
